// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Memory-mapped transmit queue between the CPU IO page and a byte-serial
// UART emitter. The CPU stores bytes into a DEPTH-entry FIFO through the data
// register. The queue presents them to the emitter over a valid/ready
// handshake, one byte per accepted transfer.
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   io_wordaddr  IO word address, one-hot decoded (DAT_BIT / CNTL_BIT)
//   io_wr        IO write strobe
//   io_wdata     IO write data (data reg: [7:0]; control: [0]=flush, [1]=clear ovf)
//   io_rdata     status word when CNTL is addressed, else zero (combinational)
//   tx_data      byte at the head of the FIFO
//   tx_valid     FIFO not empty
//   tx_ready     emitter accepts the byte this cycle
//
// Status word: [7:0] count, [8] empty, [9] full (legacy busy), [10] ovf,
//              [11] drained (empty and emitter ready).
module uart_tx_queue #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DAT_BIT    = 1,
   parameter int CNTL_BIT   = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [13:0] io_wordaddr,
   input  logic        io_wr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;

   logic push_req, cntl_wr, flush, ovf_clr;
   logic full, empty, push_ok, push_rej, pop;
   logic [7:0] count_ext;

   assign push_req = io_wr & io_wordaddr[DAT_BIT];
   assign cntl_wr  = io_wr & io_wordaddr[CNTL_BIT];
   assign flush    = cntl_wr & io_wdata[0];
   assign ovf_clr  = cntl_wr & io_wdata[1];

   assign full  = (count_q == DEPTH_CNT);
   assign empty = (count_q == '0);

   // Acceptance looks only at the occupancy at the start of the cycle, so a
   // push into a full FIFO is rejected even if a pop frees a slot this cycle.
   // A flush discards the push outright and does not count as an overflow.
   assign push_ok  = push_req & ~full & ~flush;
   assign push_rej = push_req &  full & ~flush;
   assign pop      = tx_valid & tx_ready;

   assign tx_valid = ~empty;
   assign tx_data  = mem_q[rd_ptr_q];

   assign count_ext = 8'(count_q);
   assign io_rdata  = io_wordaddr[CNTL_BIT]
                      ? {20'b0, empty & tx_ready, ovf_q, full, empty, count_ext}
                      : 32'b0;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end

      // A fresh overflow outranks a same-cycle clear so it is never lost.
      if (push_rej)     ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is intentionally not reset; the head is only observed when
   // tx_valid is high.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= io_wdata[7:0];
   end

   // Address bits other than the two decoded ones, and the upper write-data
   // bits, have no function here.
   logic unused_bits;
   assign unused_bits = ^{io_wordaddr, io_wdata[31:8]};

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

   localparam int DEPTH = 16;
   localparam logic [13:0] A_DAT  = 14'h0002;
   localparam logic [13:0] A_CNTL = 14'h0004;
   localparam logic [13:0] A_BOTH = 14'h0006;
   localparam logic [13:0] A_NONE = 14'h0008;

   logic        clk;
   logic        resetn;
   logic [13:0] io_wordaddr;
   logic        io_wr;
   logic [31:0] io_wdata;
   logic [31:0] io_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   uart_tx_queue #(.DEPTH_LOG2(4), .DAT_BIT(1), .CNTL_BIT(2)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .io_wordaddr (io_wordaddr),
      .io_wr       (io_wr),
      .io_wdata    (io_wdata),
      .io_rdata    (io_rdata),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a plain byte queue plus the sticky overflow flag.
   logic [7:0] ref_q[$];
   bit         ref_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] last_rdata;
   logic        last_valid;
   logic [7:0]  last_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_status(input logic rdy);
      int n;
      n = ref_q.size();
      return {20'b0, logic'(n == 0 && rdy), logic'(ref_ovf), logic'(n == DEPTH),
              logic'(n == 0), 8'(n)};
   endfunction

   // One clock cycle: drive inputs after the falling edge, compare the DUT
   // against the model just before the rising edge, then advance the model.
   task automatic cycle(input logic wr, input logic [13:0] addr,
                        input logic [31:0] wd, input logic rdy);
      bit push, cntl, flush, clr, full_pre, pop;
      @(negedge clk);
      io_wr = wr; io_wordaddr = addr; io_wdata = wd; tx_ready = rdy;
      #1;
      last_rdata = io_rdata; last_valid = tx_valid; last_data = tx_data;
      check("tx_valid", {31'b0, tx_valid}, {31'b0, logic'(ref_q.size() != 0)});
      if (ref_q.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, ref_q[0]});
      check("io_rdata", io_rdata, addr[2] ? ref_status(rdy) : 32'b0);

      push     = wr & addr[1];
      cntl     = wr & addr[2];
      flush    = cntl & wd[0];
      clr      = cntl & wd[1];
      full_pre = (ref_q.size() == DEPTH);
      pop      = (ref_q.size() != 0) && rdy;
      if (flush) begin
         ref_q.delete();
      end else begin
         if (pop) void'(ref_q.pop_front());
         if (push && !full_pre) ref_q.push_back(wd[7:0]);
      end
      if (push && full_pre && !flush) ref_ovf = 1'b1;
      else if (clr)                   ref_ovf = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      resetn = 1'b0; io_wr = 1'b0; io_wordaddr = '0; io_wdata = '0; tx_ready = 1'b1;
      ref_ovf = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // Idle after reset.
      cycle(1'b0, A_CNTL, 32'h0, 1'b1);
      check("rst_status", last_rdata, 32'h0000_0900);
      check("rst_valid", {31'b0, last_valid}, 32'h0);

      // Three bytes with the emitter stalled, then drained in order.
      cycle(1'b1, A_DAT, 32'h41, 1'b0);
      cycle(1'b1, A_DAT, 32'h42, 1'b0);
      cycle(1'b1, A_DAT, 32'h43, 1'b0);
      cycle(1'b0, A_CNTL, 32'h0, 1'b0);
      check("three_status", last_rdata, 32'h0000_0003);
      check("three_head", {24'b0, last_data}, 32'h41);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, A_NONE, 32'h0, 1'b1);
         check("drain_order", {24'b0, last_data}, 32'h41 + i);
      end
      cycle(1'b0, A_NONE, 32'h0, 1'b1);
      check("valid_fall", {31'b0, last_valid}, 32'h0);

      // Overfill by one, drain, clear overflow.
      for (int i = 0; i < 17; i++) cycle(1'b1, A_DAT, 32'(i), 1'b0);
      cycle(1'b0, A_CNTL, 32'h0, 1'b0);
      check("full_ovf_status", last_rdata, 32'h0000_0610);
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, A_NONE, 32'h0, 1'b1);
         check("ovf_drain", {24'b0, last_data}, 32'(i));
      end
      cycle(1'b1, A_CNTL, 32'h2, 1'b1);
      cycle(1'b0, A_CNTL, 32'h0, 1'b1);
      check("ovf_cleared", last_rdata, 32'h0000_0900);

      // Full FIFO, push and pop together: push still rejected.
      for (int i = 0; i < 16; i++) cycle(1'b1, A_DAT, 32'h80 + i, 1'b0);
      cycle(1'b1, A_DAT, 32'hEE, 1'b1);
      cycle(1'b0, A_CNTL, 32'h0, 1'b0);
      check("full_pushpop", last_rdata, 32'h0000_040F);

      // Five queued, simultaneous push/pop across pointer wrap.
      cycle(1'b1, A_CNTL, 32'h3, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, A_DAT, 32'h10 + i, 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b1, A_DAT, 32'h20 + i, 1'b1);
      cycle(1'b0, A_CNTL, 32'h0, 1'b0);
      check("steady_count", last_rdata, 32'h0000_0005);
      check("steady_head", {24'b0, last_data}, 32'h20 + 35);

      // Flush together with a data write.
      cycle(1'b1, A_BOTH, 32'h0000_0001, 1'b0);
      cycle(1'b0, A_CNTL, 32'h0, 1'b1);
      check("flush_status", last_rdata, 32'h0000_0900);
      for (int i = 0; i < 3; i++) cycle(1'b0, A_NONE, 32'h0, 1'b1);

      // Asynchronous reset in the middle of a drain.
      for (int i = 0; i < 9; i++) cycle(1'b1, A_DAT, 32'h60 + i, 1'b0);
      cycle(1'b0, A_NONE, 32'h0, 1'b1);
      cycle(1'b0, A_NONE, 32'h0, 1'b1);
      cycle(1'b0, A_CNTL, 32'h0, 1'b0);
      check("pre_reset_count", last_rdata, 32'h0000_0007);
      @(negedge clk);
      io_wr = 1'b0; io_wordaddr = A_CNTL; tx_ready = 1'b1;
      #2 resetn = 1'b0;
      #1;
      check("async_valid", {31'b0, tx_valid}, 32'h0);
      check("async_status", io_rdata, 32'h0000_0900);
      ref_q.delete();
      ref_ovf = 1'b0;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      cycle(1'b0, A_CNTL, 32'h0, 1'b1);
      check("post_reset", last_rdata, 32'h0000_0900);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [13:0] a;
         logic w;
         logic [31:0] d;
         r = $urandom_range(0, 19);
         d = $urandom;
         w = 1'b1;
         if (r < 9)       a = A_DAT;
         else if (r == 9) a = A_CNTL;
         else if (r == 10) a = A_BOTH;
         else if (r == 11) a = A_NONE;
         else begin
            w = 1'b0;
            a = ($urandom_range(0, 1) == 1) ? A_CNTL : A_NONE;
         end
         // Occasionally suppress flushes so the FIFO reaches full.
         if (a[2] && $urandom_range(0, 3) != 0) d[0] = 1'b0;
         cycle(w, a, d, logic'((i / 200) % 2 == 0 ? $urandom_range(0, 3) == 0
                                                    : $urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
